// File: rtl/dram_if_pkg.sv
// Shared types for the master_fifo DRAM request/response protocol:
// widths, command encoding, request record and responder FSM states.
package dram_if_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;

    typedef enum logic {
        CMD_WRITE = 1'b0,
        CMD_READ  = 1'b1
    } cmd_t;

    typedef struct packed {
        cmd_t              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dram_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RESP
    } resp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; head entry is visible
// combinationally on o_data. Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr_reg;
    logic [PTR_W-1:0] r_rd_ptr_reg;
    logic [CNT_W-1:0] r_count_reg;
    logic [WIDTH-1:0] w_entries [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count_reg == CNT_W'(DEPTH));
    assign o_empty = (r_count_reg == '0);
    assign o_count = r_count_reg;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = w_entries[r_rd_ptr_reg];

    // Storage is never reset; only pointers and count define validity.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry_reg;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr_reg == PTR_W'(gi))) begin
                    r_entry_reg <= i_data;
                end
            end
            assign w_entries[gi] = r_entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_reg <= '0;
            r_rd_ptr_reg <= '0;
            r_count_reg  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr_reg <= r_wr_ptr_reg + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr_reg <= r_rd_ptr_reg + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count_reg <= r_count_reg + CNT_W'(1);
                2'b01:   r_count_reg <= r_count_reg - CNT_W'(1);
                default: r_count_reg <= r_count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dram_bram_responder.sv
// BRAM-backed stand-in for the DRAM controller: queues requests, services them
// in order, and returns read data after READ_LAT cycles with rsp_rdy backpressure.
module dram_bram_responder
    import dram_if_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_LSB  = 3,
    parameter int READ_LAT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_en,
    output logic              req_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_en,
    input  logic              rsp_rdy,
    output logic              err_ovf
);

    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam int LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int REQ_W    = $bits(dram_req_t);
    localparam int FCNT_W   = ((REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1) + 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    resp_state_t       r_state_reg;
    resp_state_t       w_state_next;
    logic [LAT_W-1:0]  r_lat_reg;
    logic [LAT_W-1:0]  w_lat_next;
    logic [IDX_W-1:0]  r_idx_reg;
    logic [DATA_W-1:0] r_wdata_reg;
    logic [DATA_W-1:0] r_rsp_data_reg;
    logic              r_err_ovf_reg;
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    dram_req_t         w_req_in;
    dram_req_t         w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_rsp_en;
    logic              w_unused_bits;

    assign w_req_in.cmd  = cmd_t'(req_cmd);
    assign w_req_in.addr = req_addr;
    assign w_req_in.data = req_data;

    assign req_rdy  = !w_fifo_full;
    assign w_push   = req_en && req_rdy;
    assign rsp_en   = w_rsp_en;
    assign rsp_data = r_rsp_data_reg;
    assign err_ovf  = r_err_ovf_reg;

    // Address bits outside the word index are deliberately aliased away.
    assign w_unused_bits = ^{w_head.addr, w_fifo_count};

    sync_fifo #(
        .WIDTH(REQ_W),
        .DEPTH(REQ_DEPTH)
    ) u_req_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_data (w_req_in),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty),
        .o_count(w_fifo_count)
    );

    always_comb begin
        w_state_next = r_state_reg;
        w_lat_next   = r_lat_reg;
        w_pop        = 1'b0;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_rsp_en     = 1'b0;
        case (r_state_reg)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head.cmd == CMD_READ) begin
                        w_lat_next   = LAT_INIT;
                        w_state_next = ST_RD_WAIT;
                    end else begin
                        w_state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_wr_en      = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (r_lat_reg == '0) begin
                    w_rd_en      = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_lat_next = r_lat_reg - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    w_rsp_en     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg   <= ST_IDLE;
            r_lat_reg     <= '0;
            r_err_ovf_reg <= 1'b0;
        end else begin
            r_state_reg <= w_state_next;
            r_lat_reg   <= w_lat_next;
            if (req_en && !req_rdy) begin
                r_err_ovf_reg <= 1'b1;
            end
        end
    end

    // Dequeued request is latched so the FIFO head can move on immediately.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_idx_reg   <= w_head.addr[ADDR_LSB +: IDX_W];
            r_wdata_reg <= w_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_idx_reg] <= r_wdata_reg;
        end
        if (rst) begin
            r_rsp_data_reg <= '0;
        end else if (w_rd_en) begin
            r_rsp_data_reg <= r_mem[r_idx_reg];
        end
    end

endmodule
